// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared state encoding and default sizing for rr_arbiter
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEFAULT_N        = 8;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational fixed-priority picker, lowest set index wins
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  // Two's-complement trick isolates the lowest set bit; zero in gives zero out.
  assign gnt_o = req_i & (~req_i + {{(N-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with bounded grant hold and dead cycle on release
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  arb_state_e      state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [7:0]      hcnt_q;
  logic [N-1:0]    gnt_q;
  logic            gnt_valid_q;
  logic [IW-1:0]   gnt_id_q;
  logic            timeout_q;

  logic [N-1:0]    mask;
  logic [N-1:0]    pick_masked;
  logic [N-1:0]    pick_all;
  logic [N-1:0]    win_oh;
  logic [IW-1:0]   win_idx;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
  end

  rr_pick #(.N(N)) u_pick_masked (
    .req_i (req & mask),
    .gnt_o (pick_masked)
  );

  rr_pick #(.N(N)) u_pick_all (
    .req_i (req),
    .gnt_o (pick_all)
  );

  // Indices at or above ptr take precedence; the unmasked pick covers the wrap.
  assign win_oh = (|pick_masked) ? pick_masked : pick_all;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) win_idx = IW'(i);
    end
  end

  assign ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q     <= BUSY;
            gnt_q       <= win_oh;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= win_idx;
            ptr_q       <= ptr_d;
            hcnt_q      <= 8'd1;
          end
        end
        BUSY: begin
          // A dropped request wins over the hold limit, so no timeout then.
          if (!req[gnt_id_q] || (hcnt_q == 8'(MAX_HOLD))) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hcnt_q      <= '0;
            timeout_q   <= req[gnt_id_q];
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;

  int n_vec  = 0;
  int n_miss = 0;
  logic inv_en = 1'b0;

  rr_arbiter #(.N(8), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    check({tag, ".gnt"}, {24'd0, gnt}, {24'd0, oh});
    check({tag, ".valid"}, {31'd0, gnt_valid}, 32'd1);
    check({tag, ".id"}, {29'd0, gnt_id}, idx);
    check({tag, ".timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  task automatic expect_idle(input string tag, input logic to);
    check({tag, ".gnt"}, {24'd0, gnt}, 32'd0);
    check({tag, ".valid"}, {31'd0, gnt_valid}, 32'd0);
    check({tag, ".id"}, {29'd0, gnt_id}, 32'd0);
    check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
  endtask

  // Structural invariants sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (inv_en) begin
      logic [2:0] eid;
      eid = '0;
      for (int i = 0; i < 8; i++) if (gnt[i]) eid = 3'(i);
      check("inv.onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
      check("inv.valid", {31'd0, gnt_valid}, {31'd0, |gnt});
      check("inv.id", {29'd0, gnt_id}, {29'd0, eid});
    end
  end

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    tick();
    tick();
    inv_en = 1'b1;
    expect_idle("reset", 1'b0);

    // Idle with no requests
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_idle("noreq", 1'b0);
    end

    // Alternating 0/7 with a one-cycle drop after three granted cycles
    for (int r = 0; r < 4; r++) begin
      int h;
      h = (r % 2 == 0) ? 0 : 7;
      req = 8'b1000_0001;
      tick();
      expect_grant("alt.first", h);
      tick();
      tick();
      expect_grant("alt.held", h);
      req = 8'b1000_0001 & ~(8'd1 << h);
      tick();
      expect_idle("alt.dead", 1'b0);
    end

    // All requesting: 16-cycle forced holds, rotation 0..7 then 0
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      expect_grant("full.issue", g % 8);
      for (int c = 1; c < 16; c++) tick();
      expect_grant("full.last", g % 8);
      if (g < 8) begin
        tick();
        expect_idle("full.forced", 1'b1);
      end
    end
    // Drop on the saturating cycle counts as voluntary
    req = 8'h00;
    tick();
    expect_idle("full.vol_at_max", 1'b0);

    // ptr now 1: grant 2, late request from 5 must not preempt
    req = 8'b0000_0100;
    tick();
    expect_grant("nopre.issue", 2);
    req = 8'b0010_0100;
    tick();
    tick();
    expect_grant("nopre.held", 2);
    req = 8'b0010_0000;
    tick();
    expect_idle("nopre.dead", 1'b0);
    tick();
    expect_grant("nopre.next", 5);
    req = 8'h00;
    tick();
    expect_idle("nopre.rel", 1'b0);

    // Reset mid-grant, then ptr must be back at 0
    req = 8'b0000_1000;
    tick();
    expect_grant("rst.issue", 3);
    tick();
    tick();
    tick();
    expect_grant("rst.cycle4", 3);
    reset = 1'b1;
    tick();
    expect_idle("rst.drop", 1'b0);
    reset = 1'b0;
    req   = 8'b0000_1001;
    tick();
    expect_grant("rst.ptr0", 0);
    req = 8'h00;
    tick();
    expect_idle("rst.rel", 1'b0);

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
